// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin CPU/DMA writes onto one write port, plus a full-frame clear engine.
// Latency: an accepted transfer or clear step appears on fb_we/fb_addr/fb_data one cycle later.
// Backpressure: at most one ready per cycle, chosen by round robin; both readies are held low while the clear engine is busy.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   clr_start, clr_color          clear request pulse and fill colour (colour is sampled when the request is accepted)
//   clr_busy, clr_done            clear engine owns the write port / one-cycle pulse when the clear is finished
//   cpu_valid/ready/addr/data     CPU write requester
//   dma_valid/ready/addr/data     DMA write requester
//   fb_we, fb_addr, fb_data       registered framebuffer write port
//   err_oob, err_clr              sticky out-of-bounds flag and its clear
module fb_write_arbiter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              err_oob,
  input  logic              err_clr
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  // One extra bit so that a frame of exactly 2**ADDR_W pixels still compares correctly.
  localparam logic [ADDR_W:0]   NPIX_W = (ADDR_W+1)'(NPIX);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NPIX - 1);

  typedef enum logic { IDLE, CLEAR } state_t;
  typedef enum logic { GNT_CPU, GNT_DMA } gnt_t;

  state_t            state_q;
  gnt_t              last_gnt_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] color_q;
  logic              clr_done_q;
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_data_q;
  logic              err_oob_q;
  logic              err_oob_d;

  logic              cpu_gnt;
  logic              dma_gnt;
  logic              xfer_vld;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_oob;

  assign clr_busy = (state_q == CLEAR);

  // A lone requester always wins. On a tie, the side that did not win last time
  // is granted, so after reset (last = DMA) the CPU wins the first tie.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    xfer_addr = cpu_addr;
    xfer_data = cpu_data;
    if (!clr_busy) begin
      cpu_gnt = cpu_valid && (!dma_valid || (last_gnt_q == GNT_DMA));
      dma_gnt = dma_valid && (!cpu_valid || (last_gnt_q == GNT_CPU));
    end
    if (dma_gnt) begin
      xfer_addr = dma_addr;
      xfer_data = dma_data;
    end
    xfer_vld  = cpu_gnt || dma_gnt;
    xfer_oob  = ({1'b0, xfer_addr} >= NPIX_W);
    // A new out-of-bounds event wins over err_clr in the same cycle.
    err_oob_d = (err_oob_q && !err_clr) || (xfer_vld && xfer_oob);
  end

  assign cpu_ready = cpu_gnt;
  assign dma_ready = dma_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_DMA;
      cnt_q      <= '0;
      color_q    <= '0;
      clr_done_q <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      fb_we_q    <= 1'b0;
      clr_done_q <= 1'b0;
      err_oob_q  <= err_oob_d;
      case (state_q)
        IDLE: begin
          // A transfer in the same cycle as clr_start is still written;
          // the first clear write trails it by one cycle.
          if (xfer_vld) begin
            last_gnt_q <= dma_gnt ? GNT_DMA : GNT_CPU;
            if (!xfer_oob) begin
              fb_we_q   <= 1'b1;
              fb_addr_q <= xfer_addr;
              fb_data_q <= xfer_data;
            end
          end
          if (clr_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            color_q <= clr_color;
          end
        end
        CLEAR: begin
          // clr_start is ignored here: no restart and no colour change.
          fb_we_q   <= 1'b1;
          fb_addr_q <= cnt_q;
          fb_data_q <= color_q;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_done = clr_done_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Small frame (4x2) instance: table vectors and clear sequences.
  logic        s_clr_start = 0, s_clr_busy, s_clr_done;
  logic [23:0] s_clr_color = '0;
  logic        s_cpu_valid = 0, s_cpu_ready, s_dma_valid = 0, s_dma_ready;
  logic [18:0] s_cpu_addr = '0, s_dma_addr = '0, s_fb_addr;
  logic [23:0] s_cpu_data = '0, s_dma_data = '0, s_fb_data;
  logic        s_fb_we, s_err_oob, s_err_clr = 0;

  // Default-size (640x480) instance: boundary addresses and alternation.
  logic        b_clr_start = 0, b_clr_busy, b_clr_done;
  logic [23:0] b_clr_color = '0;
  logic        b_cpu_valid = 0, b_cpu_ready, b_dma_valid = 0, b_dma_ready;
  logic [18:0] b_cpu_addr = '0, b_dma_addr = '0, b_fb_addr;
  logic [23:0] b_cpu_data = '0, b_dma_data = '0, b_fb_data;
  logic        b_fb_we, b_err_oob, b_err_clr = 0;

  fb_write_arbiter #(.WIDTH(4), .HEIGHT(2), .ADDR_W(19), .DATA_W(24)) u_small (
    .clk(clk), .rst_n(rst_n), .clr_start(s_clr_start), .clr_color(s_clr_color),
    .clr_busy(s_clr_busy), .clr_done(s_clr_done),
    .cpu_valid(s_cpu_valid), .cpu_ready(s_cpu_ready), .cpu_addr(s_cpu_addr), .cpu_data(s_cpu_data),
    .dma_valid(s_dma_valid), .dma_ready(s_dma_ready), .dma_addr(s_dma_addr), .dma_data(s_dma_data),
    .fb_we(s_fb_we), .fb_addr(s_fb_addr), .fb_data(s_fb_data),
    .err_oob(s_err_oob), .err_clr(s_err_clr)
  );

  fb_write_arbiter u_big (
    .clk(clk), .rst_n(rst_n), .clr_start(b_clr_start), .clr_color(b_clr_color),
    .clr_busy(b_clr_busy), .clr_done(b_clr_done),
    .cpu_valid(b_cpu_valid), .cpu_ready(b_cpu_ready), .cpu_addr(b_cpu_addr), .cpu_data(b_cpu_data),
    .dma_valid(b_dma_valid), .dma_ready(b_dma_ready), .dma_addr(b_dma_addr), .dma_data(b_dma_data),
    .fb_we(b_fb_we), .fb_addr(b_fb_addr), .fb_data(b_fb_data),
    .err_oob(b_err_oob), .err_clr(b_err_clr)
  );

  typedef struct {
    logic        cv;
    logic [18:0] ca;
    logic [23:0] cd;
    logic        dv;
    logic [18:0] da;
    logic [23:0] dd;
    logic        ec;
    logic        e_cr;
    logic        e_dr;
    logic        e_we;
    logic [18:0] e_a;
    logic [23:0] e_d;
    logic        e_oob;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    //          cv  ca      cd          dv  da      dd          ec  cr  dr  we  a      d           oob
    tbl[0]  = '{0, 19'd0, 24'h000000, 0, 19'd0, 24'h000000, 0,  0,  0,  0, 19'd0, 24'h000000, 0};
    tbl[1]  = '{1, 19'd2, 24'h00000A, 1, 19'd3, 24'h00000B, 0,  1,  0,  1, 19'd2, 24'h00000A, 0};
    tbl[2]  = '{1, 19'd2, 24'h00000A, 1, 19'd3, 24'h00000B, 0,  0,  1,  1, 19'd3, 24'h00000B, 0};
    tbl[3]  = '{0, 19'd0, 24'h000000, 1, 19'd4, 24'h00000C, 0,  0,  1,  1, 19'd4, 24'h00000C, 0};
    tbl[4]  = '{0, 19'd0, 24'h000000, 1, 19'd5, 24'h00000D, 0,  0,  1,  1, 19'd5, 24'h00000D, 0};
    tbl[5]  = '{1, 19'd6, 24'h00000E, 1, 19'd7, 24'h00000F, 0,  1,  0,  1, 19'd6, 24'h00000E, 0};
    tbl[6]  = '{1, 19'd1, 24'h000001, 0, 19'd0, 24'h000000, 0,  1,  0,  1, 19'd1, 24'h000001, 0};
    tbl[7]  = '{0, 19'd0, 24'h000000, 0, 19'd0, 24'h000000, 0,  0,  0,  0, 19'd1, 24'h000001, 0};
    tbl[8]  = '{1, 19'd8, 24'h000099, 0, 19'd0, 24'h000000, 0,  1,  0,  0, 19'd1, 24'h000001, 1};
    tbl[9]  = '{0, 19'd0, 24'h000000, 0, 19'd0, 24'h000000, 0,  0,  0,  0, 19'd1, 24'h000001, 1};
    tbl[10] = '{0, 19'd0, 24'h000000, 0, 19'd0, 24'h000000, 1,  0,  0,  0, 19'd1, 24'h000001, 0};
    tbl[11] = '{0, 19'd0, 24'h000000, 1, 19'd9, 24'h000077, 1,  0,  1,  0, 19'd1, 24'h000001, 1};
    tbl[12] = '{0, 19'd0, 24'h000000, 0, 19'd0, 24'h000000, 1,  0,  0,  0, 19'd1, 24'h000001, 0};
    tbl[13] = '{1, 19'd0, 24'h123456, 1, 19'd7, 24'h654321, 0,  1,  0,  1, 19'd0, 24'h123456, 0};
    tbl[14] = '{0, 19'd0, 24'h000000, 1, 19'd7, 24'h654321, 0,  0,  1,  1, 19'd7, 24'h654321, 0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fb_we",    32'(s_fb_we), 32'd0);
    chk("rst_fb_addr",  32'(s_fb_addr), 32'd0);
    chk("rst_fb_data",  32'(s_fb_data), 32'd0);
    chk("rst_clr_busy", 32'(s_clr_busy), 32'd0);
    chk("rst_clr_done", 32'(s_clr_done), 32'd0);
    chk("rst_err_oob",  32'(s_err_oob), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven arbitration / out-of-bounds vectors on the small frame.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      s_cpu_valid = tbl[i].cv; s_cpu_addr = tbl[i].ca; s_cpu_data = tbl[i].cd;
      s_dma_valid = tbl[i].dv; s_dma_addr = tbl[i].da; s_dma_data = tbl[i].dd;
      s_err_clr   = tbl[i].ec;
      #1;
      chk($sformatf("v%0d_cpu_ready", i), 32'(s_cpu_ready), 32'(tbl[i].e_cr));
      chk($sformatf("v%0d_dma_ready", i), 32'(s_dma_ready), 32'(tbl[i].e_dr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fb_we", i),   32'(s_fb_we),   32'(tbl[i].e_we));
      chk($sformatf("v%0d_fb_addr", i), 32'(s_fb_addr), 32'(tbl[i].e_a));
      chk($sformatf("v%0d_fb_data", i), 32'(s_fb_data), 32'(tbl[i].e_d));
      chk($sformatf("v%0d_err_oob", i), 32'(s_err_oob), 32'(tbl[i].e_oob));
    end

    // Clear requested in the same cycle as a CPU transfer (last grant was DMA).
    @(negedge clk);
    s_err_clr = 0; s_dma_valid = 0;
    s_cpu_valid = 1; s_cpu_addr = 19'd3; s_cpu_data = 24'h777777;
    s_clr_start = 1; s_clr_color = 24'h00FF00;
    #1;
    chk("clr0_cpu_ready", 32'(s_cpu_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("clr0_fb_we",    32'(s_fb_we), 32'd1);
    chk("clr0_fb_addr",  32'(s_fb_addr), 32'd3);
    chk("clr0_fb_data",  32'(s_fb_data), 32'h777777);
    chk("clr0_clr_busy", 32'(s_clr_busy), 32'd1);

    // Eight clear writes; both requesters stall, a second clr_start is ignored.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_cpu_valid = 1; s_cpu_addr = 19'd1; s_cpu_data = 24'h111111;
      s_dma_valid = 1; s_dma_addr = 19'd2; s_dma_data = 24'h222222;
      s_clr_start = (k == 2);
      s_clr_color = (k == 2) ? 24'h0000FF : 24'h00FF00;
      #1;
      chk($sformatf("clr%0d_cpu_ready", k), 32'(s_cpu_ready), 32'd0);
      chk($sformatf("clr%0d_dma_ready", k), 32'(s_dma_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("clr%0d_fb_we", k),    32'(s_fb_we), 32'd1);
      chk($sformatf("clr%0d_fb_addr", k),  32'(s_fb_addr), 32'(k));
      chk($sformatf("clr%0d_fb_data", k),  32'(s_fb_data), 32'h00FF00);
      chk($sformatf("clr%0d_clr_done", k), 32'(s_clr_done), 32'(k == 7));
      chk($sformatf("clr%0d_clr_busy", k), 32'(s_clr_busy), 32'(k != 7));
    end

    // Stalled requests resume; CPU won last before the clear, so DMA goes first.
    @(negedge clk);
    s_clr_start = 0;
    #1;
    chk("post_dma_ready", 32'(s_dma_ready), 32'd1);
    chk("post_cpu_ready", 32'(s_cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_fb_addr",  32'(s_fb_addr), 32'd2);
    chk("post_fb_data",  32'(s_fb_data), 32'h222222);
    chk("post_clr_done", 32'(s_clr_done), 32'd0);
    @(negedge clk);
    s_dma_valid = 0;
    #1;
    chk("post2_cpu_ready", 32'(s_cpu_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("post2_fb_addr", 32'(s_fb_addr), 32'd1);
    @(negedge clk);
    s_cpu_valid = 0;
    @(posedge clk);
    #1;
    chk("post3_fb_we", 32'(s_fb_we), 32'd0);

    // Default-size instance: alternation 5,9,5,9... starting with CPU.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      b_cpu_valid = 1; b_cpu_addr = 19'd5; b_cpu_data = 24'h050505;
      b_dma_valid = 1; b_dma_addr = 19'd9; b_dma_data = 24'h090909;
      #1;
      chk($sformatf("rr%0d_cpu_ready", k), 32'(b_cpu_ready), 32'(k % 2 == 0));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_fb_addr", k), 32'(b_fb_addr), (k % 2 == 0) ? 32'd5 : 32'd9);
    end

    // Last in-bounds pixel.
    @(negedge clk);
    b_dma_valid = 0;
    b_cpu_addr = 19'd307199; b_cpu_data = 24'hFF0000;
    @(posedge clk);
    #1;
    chk("edge_fb_we",   32'(b_fb_we), 32'd1);
    chk("edge_fb_addr", 32'(b_fb_addr), 32'd307199);
    chk("edge_fb_data", 32'(b_fb_data), 32'hFF0000);
    chk("edge_err_oob", 32'(b_err_oob), 32'd0);

    // First out-of-bounds address from DMA.
    @(negedge clk);
    b_cpu_valid = 0;
    b_dma_valid = 1; b_dma_addr = 19'd307200; b_dma_data = 24'hABCDEF;
    #1;
    chk("oob_dma_ready", 32'(b_dma_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("oob_fb_we",   32'(b_fb_we), 32'd0);
    chk("oob_err_oob", 32'(b_err_oob), 32'd1);
    @(negedge clk);
    b_dma_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("oob_sticky", 32'(b_err_oob), 32'd1);
    @(negedge clk);
    b_err_clr = 1;
    @(negedge clk);
    b_err_clr = 0;
    #1;
    chk("oob_cleared", 32'(b_err_oob), 32'd0);

    // Reset while the clear is at address 3.
    @(negedge clk);
    s_clr_start = 1; s_clr_color = 24'h0000FF;
    @(negedge clk);
    s_clr_start = 0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort%0d_fb_addr", j), 32'(s_fb_addr), 32'(j));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_fb_we",    32'(s_fb_we), 32'd0);
    chk("abort_clr_busy", 32'(s_clr_busy), 32'd0);
    chk("abort_clr_done", 32'(s_clr_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("after%0d_fb_we", j),    32'(s_fb_we), 32'd0);
      chk($sformatf("after%0d_clr_done", j), 32'(s_clr_done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 640, active pixels per line.
REQ-002 Parameter HEIGHT, default 480, active lines per frame.
REQ-003 Parameter ADDR_W, default 19, framebuffer address width; DATA_W default 24, pixel width {R[23:16],G[15:8],B[7:0]}.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clr_start  in  1  one-cycle pulse; requests full-frame clear.
REQ-007 clr_color  in  DATA_W  fill pixel; sampled only on the accepted clr_start cycle.
REQ-008 clr_busy  out  1  high while the clear engine owns the write port.
REQ-009 clr_done  out  1  one-cycle pulse after the last clear write is issued.
REQ-010 cpu_valid / cpu_ready  in / out  1 / 1  CPU write handshake.
REQ-011 cpu_addr / cpu_data  in  ADDR_W / DATA_W  CPU write address and pixel.
REQ-012 dma_valid / dma_ready  in / out  1 / 1  DMA write handshake.
REQ-013 dma_addr / dma_data  in  ADDR_W / DATA_W  DMA write address and pixel.
REQ-014 fb_we  out  1  framebuffer write enable.
REQ-015 fb_addr / fb_data  out  ADDR_W / DATA_W  framebuffer write address and pixel.
REQ-016 err_oob  out  1  sticky out-of-bounds write flag.
REQ-017 err_clr  in  1  clears err_oob.

Function
REQ-018 The block SHALL permit at most one write per cycle onto the fb_* port; a transfer is valid&ready on a requester.
REQ-019 cpu_ready and dma_ready SHALL be combinational functions of valids, clr_busy and the round-robin pointer; at most one SHALL be high per cycle; neither SHALL be high while clr_busy=1.
REQ-020 Round-robin: a single pointer last_gnt SHALL hold the last requester that completed a transfer; when both valid, the requester other than last_gnt SHALL be granted; when one valid, it SHALL be granted regardless of last_gnt.
REQ-021 last_gnt SHALL update only on a completed transfer; a requester SHALL hold addr/data stable while valid&!ready.
REQ-022 fb_we/fb_addr/fb_data SHALL be registered: a transfer in cycle N drives fb_we=1 with that address/data in cycle N+1 only; otherwise fb_we=0, fb_addr/fb_data hold last value.
REQ-023 A transfer with addr >= WIDTH*HEIGHT SHALL be accepted (ready asserted), SHALL NOT assert fb_we, and SHALL set err_oob in cycle N+1.
REQ-024 err_oob SHALL remain set until err_clr=1; err_clr and a new out-of-bounds event in the same cycle SHALL leave err_oob=1.
REQ-025 Clear FSM states IDLE and CLEAR; IDLE->CLEAR on clr_start; clr_color latched and address counter set to 0 on that edge.
REQ-026 In CLEAR, clr_busy=1 and one write per cycle SHALL be issued with fb_addr=counter, fb_data=latched color, counter incrementing by 1 (registered output, same latency as REQ-022).
REQ-027 When counter = WIDTH*HEIGHT-1 is issued, FSM SHALL return to IDLE, clr_busy SHALL drop next cycle, clr_done SHALL pulse for exactly that one cycle.
REQ-028 A full clear SHALL take exactly WIDTH*HEIGHT cycles of fb_we=1 with contiguous addresses 0..WIDTH*HEIGHT-1.
REQ-029 clr_start while CLEAR SHALL be ignored (no restart, no color change).
REQ-030 clr_start in a cycle where a CPU/DMA transfer completes: that transfer SHALL complete and be written; CLEAR begins next cycle with its write trailing by one cycle.
REQ-031 Pending requests stalled during CLEAR SHALL be served per REQ-020 once clr_busy=0; last_gnt SHALL be unchanged by the clear.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: FSM=IDLE, counter=0, clr_busy=0, clr_done=0, fb_we=0, fb_addr=0, fb_data=0, err_oob=0, last_gnt=DMA (CPU wins the first tie).
REQ-033 rst_n asserted mid-clear SHALL abort the clear with no clr_done; after release, no further clear writes SHALL occur.

Verification
REQ-034 Both valid continuously, addrs 5 (CPU) / 9 (DMA) -> after reset fb_addr sequence 5,9,5,9..., grants alternate every cycle starting with CPU.
REQ-035 CPU only, addr 307199 data 0xFF0000 -> next cycle fb_we=1 fb_addr=307199 fb_data=0xFF0000, err_oob=0.
REQ-036 DMA addr 307200 -> dma_ready=1, fb_we=0 next cycle, err_oob=1 and stays 1 until err_clr pulse.
REQ-037 clr_start with clr_color=0x00FF00, WIDTH=4 HEIGHT=2 -> fb_we=1 for 8 consecutive cycles, addrs 0..7, data 0x00FF00, clr_done pulse once, CPU/DMA ready=0 throughout.
REQ-038 Second clr_start during clear with color 0x0000FF -> ignored; all 8 writes keep 0x00FF00.
REQ-039 rst_n low at clear address 3 -> fb_we=0 immediately, clr_busy=0, no clr_done, no writes after release.
